// File: rtl/aes_pkg.sv
// Shared types and round-count constants for the AES inverse-cipher datapath.
package aes_pkg;

  localparam int AES_NR128 = 10;
  localparam int AES_NR192 = 12;
  localparam int AES_NR256 = 14;

  typedef logic [127:0] aes_state_t;

  typedef struct packed {
    aes_state_t state;
    logic       mix;
    logic       last;
    logic [3:0] round;
  } aes_beat_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } aes_ctl_st_t;

endpackage

// File: rtl/aes_skid_buf.sv
// Two-entry valid/ready buffer: output register plus one skid entry, 1-cycle latency.
// o_rdy is registered (skid empty), so at most one beat lands after i_rdy falls.
module aes_skid_buf #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vld,
  output logic o_rdy,
  input  T     i_dat,
  output logic o_vld,
  input  logic i_rdy,
  output T     o_dat
);

  logic r_out_vld;
  logic r_skid_vld;
  T     r_out_dat;
  T     r_skid_dat;
  logic w_acc;

  assign w_acc = i_vld && !r_skid_vld;
  assign o_rdy = !r_skid_vld;
  assign o_vld = r_out_vld;
  assign o_dat = r_out_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_dat  <= '0;
      r_skid_vld <= 1'b0;
      r_skid_dat <= '0;
    end else if (r_skid_vld) begin
      // Input is closed while the skid entry is occupied; it only drains.
      if (i_rdy) begin
        r_out_dat  <= r_skid_dat;
        r_skid_vld <= 1'b0;
      end
    end else if (!r_out_vld || i_rdy) begin
      r_out_vld <= w_acc;
      if (w_acc) begin
        r_out_dat <= i_dat;
      end
    end else if (w_acc) begin
      r_skid_vld <= 1'b1;
      r_skid_dat <= i_dat;
    end
  end

endmodule

// File: rtl/aes_inv_addkey_stage.sv
// Registered AddRoundKey stage with per-block round tracking, 1-cycle latency.
// Output decoupled by a two-entry skid buffer; in_ready is registered.
module aes_inv_addkey_stage
  import aes_pkg::*;
#(
  parameter int NR = AES_NR128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic [127:0] in_state,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         out_mix,
  output logic         out_last,
  output logic [3:0]   out_round,
  output logic         err
);

  localparam logic [3:0] NR_L  = 4'(NR);
  localparam logic [3:0] NR_M1 = 4'(NR - 1);

  aes_ctl_st_t r_state;
  aes_ctl_st_t w_nxt_state;
  logic [3:0]  r_cnt;
  logic [3:0]  w_nxt_cnt;
  logic [3:0]  w_round;
  logic        r_err;
  logic        w_err_set;
  logic        w_acc;
  logic        w_emit;
  logic        w_buf_vld;
  logic        w_buf_rdy;
  aes_beat_t   w_beat;
  aes_beat_t   w_out_beat;

  assign w_acc = in_valid && w_buf_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_err   <= r_err | w_err_set;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_err_set   = 1'b0;
    if (w_acc) begin
      if (in_first) begin
        // A ciphertext beat mid-block abandons the old block and restarts.
        w_err_set   = (r_state == ST_RUN);
        w_nxt_state = ST_RUN;
        w_nxt_cnt   = NR_M1;
      end else if (r_state == ST_IDLE) begin
        w_err_set = 1'b1;
      end else if (r_cnt == 4'd0) begin
        w_nxt_state = ST_IDLE;
      end else begin
        w_nxt_cnt = r_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_round      = (in_first || r_state == ST_IDLE) ? NR_L : r_cnt;
    w_emit       = in_first || (r_state == ST_RUN);
    w_buf_vld    = in_valid && w_emit;
    w_beat.state = in_state ^ rk;
    w_beat.mix   = (w_round != 4'd0) && (w_round != NR_L);
    w_beat.last  = (w_round == 4'd0);
    w_beat.round = w_round;
  end

  aes_skid_buf #(
    .T(aes_beat_t)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (w_buf_vld),
    .o_rdy (w_buf_rdy),
    .i_dat (w_beat),
    .o_vld (out_valid),
    .i_rdy (out_ready),
    .o_dat (w_out_beat)
  );

  assign in_ready  = w_buf_rdy;
  assign rk_idx    = w_round;
  assign out_state = w_out_beat.state;
  assign out_mix   = w_out_beat.mix;
  assign out_last  = w_out_beat.last;
  assign out_round = w_out_beat.round;
  assign err       = r_err;

endmodule
